// File: rtl/seq_det_arbiter.sv
// seq_det_arbiter: shares one serial sequence-detector lane among NREQ requesters.
// A granted word is shifted out MSB-first after a detector clear pulse; hit pulses
// seen during the shift and drain window are counted and returned with the requester id.
// Optional build macro SEQ_ARB_FIXED_PRIO_EN: lowest asserted index always wins
// (round-robin pointer removed). Default build is round-robin.
module seq_det_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned DRAIN_CYC = 2,
    localparam int unsigned CNT_W    = $clog2(WORD_W + DRAIN_CYC + 1),
    localparam int unsigned ID_W     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WORD_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     det_reset,
    output logic                     det_bit,
    input  logic                     det_hit,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [CNT_W-1:0]         rsp_hits,
    output logic                     busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_SHIFT  = 3'd2,
        S_DRAIN  = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    hit_q, hit_d;
    logic [CNT_W-1:0]    hit_inc;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0]    rsp_hits_q, rsp_hits_d;
    logic [ID_W-1:0]     rr_ptr;
    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    int unsigned         cand;
    logic [WORD_W-1:0]   req_word [NREQ];

    // Unpack the flat request bus into per-requester words
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_word
        assign req_word[gi] = req_data[gi*WORD_W +: WORD_W];
    end

`ifdef SEQ_ARB_FIXED_PRIO_EN
    // Fixed priority: search always starts at index 0
    assign rr_ptr = '0;
`else
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    // Round-robin pointer advances past the requester just reported
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == S_REPORT) begin
            rr_ptr_d = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + ID_W'(1);
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (reset) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end

    assign rr_ptr = rr_ptr_q;
`endif

    // Pick the first valid requester starting from rr_ptr, wrapping modulo NREQ
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < int'(NREQ); i++) begin
            cand = (32'(rr_ptr) + 32'(i)) % NREQ;
            if (!grant_found && req_valid[ID_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    // One-hot accept pulse, only while idle and out of reset
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && !reset && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign hit_inc = (hit_q == {CNT_W{1'b1}}) ? hit_q : hit_q + CNT_W'(1);

    // Next-state and datapath update for the service sequence
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        id_d       = id_q;
        cnt_d      = cnt_q;
        hit_d      = hit_q;
        rsp_id_d   = rsp_id_q;
        rsp_hits_d = rsp_hits_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    shift_d = req_word[grant_idx];
                    id_d    = grant_idx;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                hit_d   = '0;
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                shift_d = {shift_q[WORD_W-2:0], 1'b0};
                if (det_hit) hit_d = hit_inc;
                if (cnt_q == CNT_W'(WORD_W - 1)) begin
                    cnt_d   = '0;
                    state_d = (DRAIN_CYC == 0) ? S_REPORT : S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (det_hit) hit_d = hit_inc;
                if (32'(cnt_q) + 32'd1 >= DRAIN_CYC) begin
                    cnt_d   = '0;
                    state_d = S_REPORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Response fields load on entry to REPORT and hold until the next one
        if (state_d == S_REPORT) begin
            rsp_id_d   = id_q;
            rsp_hits_d = hit_d;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            id_q       <= '0;
            cnt_q      <= '0;
            hit_q      <= '0;
            rsp_id_q   <= '0;
            rsp_hits_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
            hit_q      <= hit_d;
            rsp_id_q   <= rsp_id_d;
            rsp_hits_q <= rsp_hits_d;
        end
    end

    assign det_reset = reset || (state_q == S_CLEAR);
    assign det_bit   = (state_q == S_SHIFT) && shift_q[WORD_W-1];
    assign rsp_valid = (state_q == S_REPORT);
    assign busy      = (state_q != S_IDLE);
    assign rsp_id    = rsp_id_q;
    assign rsp_hits  = rsp_hits_q;

endmodule
